iomem_dbg_master: RTL and testbench

- Byte-stream debug bridge that acts as an initiator on the PicoSoC iomem bus.
- It sits between a byte-level command source (e.g. a UART receiver on the host link) and the iomem peripheral address space.
- It decodes read and write commands, issues single iomem transactions, and returns status or read data as a response byte stream.
- It lets a host poke GPIO and other iomem peripherals without firmware involvement.

---
 rtl/iomem_dbg_pkg.sv | 20 ++
 rtl/iomem_dbg_rsp_ser.sv | 39 +++
 rtl/iomem_dbg_master.sv | 165 ++++++++++++++++
 tb/tb_iomem_dbg_master.sv | 346 ++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/iomem_dbg_pkg.sv
// Shared constants and state encoding for the iomem debug bridge.
package iomem_dbg_pkg;

  localparam logic [7:0] OP_WRITE = 8'h57;
  localparam logic [7:0] OP_READ  = 8'h52;

  localparam logic [7:0] RSP_ACK = 8'h4B;
  localparam logic [7:0] RSP_ERR = 8'h3F;
  localparam logic [7:0] RSP_TMO = 8'h54;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_ADDR,
    ST_STRB,
    ST_DATA,
    ST_BUS,
    ST_RESP
  } state_t;

endpackage

// File: rtl/iomem_dbg_rsp_ser.sv
// Response serializer: emits 1 or 4 bytes MSB first over a valid/ready handshake.
module iomem_dbg_rsp_ser
  import iomem_dbg_pkg::*;
(
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic        load_four,
  input  logic [31:0] load_data,
  input  logic        rsp_ready,
  output logic        rsp_valid,
  output logic [7:0]  rsp_data,
  output logic        last_done
);

  logic [31:0] sh_q;
  logic [2:0]  left_q;
  logic        fire;

  assign rsp_valid = (left_q != 3'd0);
  assign rsp_data  = sh_q[31:24];
  assign fire      = rsp_valid && rsp_ready;
  assign last_done = fire && (left_q == 3'd1);

  // A single-byte response is loaded into the top byte so both lengths share one path.
  always_ff @(posedge clk) begin
    if (reset) begin
      sh_q   <= 32'h0;
      left_q <= 3'd0;
    end else if (load) begin
      sh_q   <= load_data;
      left_q <= load_four ? 3'd4 : 3'd1;
    end else if (fire) begin
      sh_q   <= {sh_q[23:0], 8'h00};
      left_q <= left_q - 3'd1;
    end
  end

endmodule

// File: rtl/iomem_dbg_master.sv
// Byte-stream debug bridge issuing single iomem transactions from host commands.
// Optional bus timeout enabled by defining IOMEM_DBG_TIMEOUT_EN.
module iomem_dbg_master
  import iomem_dbg_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 1024
)(
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  output logic        cmd_ready,
  input  logic [7:0]  cmd_data,
  output logic        rsp_valid,
  input  logic        rsp_ready,
  output logic [7:0]  rsp_data,
  output logic        iomem_valid,
  input  logic        iomem_ready,
  output logic [3:0]  iomem_wstrb,
  output logic [31:0] iomem_addr,
  output logic [31:0] iomem_wdata,
  input  logic [31:0] iomem_rdata,
  output logic        busy
);

  // state   | meaning
  // IDLE    | waiting for opcode byte
  // ADDR    | shifting in 4 address bytes
  // STRB    | latching write strobe nibble
  // DATA    | shifting in 4 write data bytes
  // BUS     | iomem_valid high, waiting for iomem_ready
  // RESP    | serializer draining the response

  if (TIMEOUT_CYCLES < 2 || TIMEOUT_CYCLES > 65535) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be within 2..65535");
  end

  state_t      state_q, state_d;
  logic        is_write_q;
  logic [1:0]  cnt_q;
  logic [31:0] addr_q;
  logic [31:0] wdata_q;
  logic [3:0]  wstrb_q;
  logic        cmd_fire;
  logic        tmo_hit;
  logic        ser_load;
  logic        ser_four;
  logic [31:0] ser_data;
  logic        ser_done;

  assign cmd_ready = !reset && (state_q == ST_IDLE || state_q == ST_ADDR ||
                                state_q == ST_STRB || state_q == ST_DATA);
  assign cmd_fire    = cmd_valid && cmd_ready;
  assign iomem_valid = (state_q == ST_BUS);
  assign iomem_addr  = addr_q;
  assign iomem_wdata = wdata_q;
  assign iomem_wstrb = wstrb_q;
  assign busy        = (state_q != ST_IDLE);

`ifdef IOMEM_DBG_TIMEOUT_EN
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT_CYCLES - 1);
  logic [15:0] tmo_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || state_q != ST_BUS) tmo_cnt_q <= 16'h0;
    else                            tmo_cnt_q <= tmo_cnt_q + 16'h1;
  end

  assign tmo_hit = (state_q == ST_BUS) && (tmo_cnt_q == TMO_LAST);
`else
  assign tmo_hit = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (reset) state_q <= ST_IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d  = state_q;
    ser_load = 1'b0;
    ser_four = 1'b0;
    ser_data = 32'h0;
    case (state_q)
      ST_IDLE: begin
        if (cmd_fire) begin
          if (cmd_data == OP_WRITE || cmd_data == OP_READ) begin
            state_d = ST_ADDR;
          end else begin
            state_d  = ST_RESP;
            ser_load = 1'b1;
            ser_data = {RSP_ERR, 24'h0};
          end
        end
      end
      ST_ADDR: begin
        if (cmd_fire && cnt_q == 2'd3) state_d = is_write_q ? ST_STRB : ST_BUS;
      end
      ST_STRB: begin
        if (cmd_fire) state_d = ST_DATA;
      end
      ST_DATA: begin
        if (cmd_fire && cnt_q == 2'd3) state_d = ST_BUS;
      end
      ST_BUS: begin
        // Ready takes priority over a timeout landing on the same edge.
        if (iomem_ready) begin
          state_d  = ST_RESP;
          ser_load = 1'b1;
          ser_four = !is_write_q;
          ser_data = is_write_q ? {RSP_ACK, 24'h0} : iomem_rdata;
        end else if (tmo_hit) begin
          state_d  = ST_RESP;
          ser_load = 1'b1;
          ser_data = {RSP_TMO, 24'h0};
        end
      end
      ST_RESP: begin
        if (ser_done) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Strobe cleared on every opcode so a read always reaches the bus with wstrb=0.
  always_ff @(posedge clk) begin
    if (reset) begin
      is_write_q <= 1'b0;
      cnt_q      <= 2'd0;
      addr_q     <= 32'h0;
      wdata_q    <= 32'h0;
      wstrb_q    <= 4'h0;
    end else if (cmd_fire) begin
      case (state_q)
        ST_IDLE: begin
          is_write_q <= (cmd_data == OP_WRITE);
          cnt_q      <= 2'd0;
          wstrb_q    <= 4'h0;
        end
        ST_ADDR: begin
          addr_q <= {addr_q[23:0], cmd_data};
          cnt_q  <= cnt_q + 2'd1;
        end
        ST_STRB: wstrb_q <= cmd_data[3:0];
        ST_DATA: begin
          wdata_q <= {wdata_q[23:0], cmd_data};
          cnt_q   <= cnt_q + 2'd1;
        end
        default: ;
      endcase
    end
  end

  iomem_dbg_rsp_ser u_rsp_ser (
    .clk       (clk),
    .reset     (reset),
    .load      (ser_load),
    .load_four (ser_four),
    .load_data (ser_data),
    .rsp_ready (rsp_ready),
    .rsp_valid (rsp_valid),
    .rsp_data  (rsp_data),
    .last_done (ser_done)
  );

endmodule

// File: tb/tb_iomem_dbg_master.sv
// Directed bench for iomem_dbg_master with response scoreboard and bus responder.
module tb_iomem_dbg_master;

  localparam int unsigned TMO = 8;

  logic        clk = 1'b0;
  logic        reset;
  logic        cmd_valid;
  logic        cmd_ready;
  logic [7:0]  cmd_data;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [7:0]  rsp_data;
  logic        iomem_valid;
  logic        iomem_ready;
  logic [3:0]  iomem_wstrb;
  logic [31:0] iomem_addr;
  logic [31:0] iomem_wdata;
  logic [31:0] iomem_rdata;
  logic        busy;

  always #5 clk = ~clk;

  iomem_dbg_master #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk         (clk),
    .reset       (reset),
    .cmd_valid   (cmd_valid),
    .cmd_ready   (cmd_ready),
    .cmd_data    (cmd_data),
    .rsp_valid   (rsp_valid),
    .rsp_ready   (rsp_ready),
    .rsp_data    (rsp_data),
    .iomem_valid (iomem_valid),
    .iomem_ready (iomem_ready),
    .iomem_wstrb (iomem_wstrb),
    .iomem_addr  (iomem_addr),
    .iomem_wdata (iomem_wdata),
    .iomem_rdata (iomem_rdata),
    .busy        (busy)
  );

  int n_pass = 0, n_fail = 0;
  int m_pass = 0, m_fail = 0;

  logic [7:0] exp_q[$];
  int         rsp_idx = 0;

  // responder controls
  bit          resp_en = 1'b1;
  int          resp_wait = 0;
  logic [31:0] resp_data = 32'h0;

  // monitor capture
  int          bus_cnt = 0;
  logic [31:0] bus_addr, bus_wdata;
  logic [3:0]  bus_wstrb;
  int          last_vlen = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic mcheck(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    assert (obs === exp) m_pass++;
    else begin
      m_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // iomem responder: ready after resp_wait idle valid cycles, one-cycle pulse
  initial begin
    int wait_cnt = 0;
    iomem_ready = 1'b0;
    iomem_rdata = 32'h0;
    forever begin
      @(posedge clk);
      #1;
      iomem_ready = 1'b0;
      if (iomem_valid && resp_en) begin
        if (wait_cnt == resp_wait) begin
          iomem_ready = 1'b1;
          iomem_rdata = resp_data;
          wait_cnt    = 0;
        end else begin
          wait_cnt++;
        end
      end else begin
        wait_cnt = 0;
      end
    end
  end

  // monitor: bus protocol, response scoreboard, backpressure hold
  initial begin
    bit          chk_after = 1'b0;
    bit          prev_valid = 1'b0;
    bit          stall = 1'b0;
    int          vlen = 0;
    logic [31:0] p_addr = 32'h0, p_wdata = 32'h0;
    logic [3:0]  p_wstrb = 4'h0;
    logic [7:0]  held = 8'h0;
    forever begin
      @(negedge clk);
      if (reset) begin
        chk_after  = 1'b0;
        prev_valid = 1'b0;
        stall      = 1'b0;
        vlen       = 0;
      end else begin
        if (chk_after) begin
          mcheck("valid_after_ready", iomem_valid, 0);
          mcheck("rsp_latency", rsp_valid, 1);
          chk_after = 1'b0;
        end
        if (iomem_valid && prev_valid)
          mcheck("bus_stable", {31'd0, (iomem_addr == p_addr) && (iomem_wdata == p_wdata) &&
                                       (iomem_wstrb == p_wstrb)}, 1);
        if (iomem_valid) begin
          vlen++;
          if (iomem_ready) begin
            bus_addr  = iomem_addr;
            bus_wdata = iomem_wdata;
            bus_wstrb = iomem_wstrb;
            bus_cnt++;
            chk_after = 1'b1;
          end
        end else if (vlen != 0) begin
          last_vlen = vlen;
          vlen      = 0;
        end
        prev_valid = iomem_valid;
        p_addr     = iomem_addr;
        p_wdata    = iomem_wdata;
        p_wstrb    = iomem_wstrb;

        if (stall) begin
          mcheck("rsp_hold", {23'd0, rsp_valid, rsp_data}, {24'd1, held});
          mcheck("cmd_ready_stall", cmd_ready, 0);
        end
        stall = rsp_valid && !rsp_ready;
        held  = rsp_data;

        if (rsp_valid && rsp_ready) begin
          if (rsp_idx < exp_q.size()) mcheck("rsp_byte", rsp_data, exp_q[rsp_idx]);
          else                        mcheck("rsp_unexpected", rsp_idx, exp_q.size());
          rsp_idx++;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic send_byte(input logic [7:0] b);
    bit ok = 1'b0;
    cmd_valid = 1'b1;
    cmd_data  = b;
    for (int i = 0; i < 200; i++) begin
      @(negedge clk);
      if (cmd_ready) begin
        ok = 1'b1;
        break;
      end
    end
    check("cmd_accept", ok, 1);
    @(posedge clk);
    #1;
    cmd_valid = 1'b0;
  endtask

  task automatic send_read(input logic [31:0] a);
    send_byte(8'h52);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
  endtask

  task automatic send_write(input logic [31:0] a, input logic [7:0] s, input logic [31:0] d);
    send_byte(8'h57);
    for (int i = 3; i >= 0; i--) send_byte(a[i*8 +: 8]);
    send_byte(s);
    for (int i = 3; i >= 0; i--) send_byte(d[i*8 +: 8]);
  endtask

  task automatic push4(input logic [31:0] w);
    for (int i = 3; i >= 0; i--) exp_q.push_back(w[i*8 +: 8]);
  endtask

  task automatic wait_idle(input string tag);
    bit ok = 1'b0;
    for (int i = 0; i < 300; i++) begin
      @(negedge clk);
      if (!busy && rsp_idx == exp_q.size()) begin
        ok = 1'b1;
        break;
      end
    end
    check(tag, ok, 1);
    @(posedge clk);
    #1;
  endtask

  initial begin
    int b0;
    int base;
    reset     = 1'b1;
    cmd_valid = 1'b0;
    cmd_data  = 8'h00;
    rsp_ready = 1'b1;

    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_cmd_ready", cmd_ready, 0);
    check("rst_iomem_valid", iomem_valid, 0);
    check("rst_rsp_valid", rsp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_rsp_data", rsp_data, 0);
    check("rst_bus_regs", {iomem_wstrb, iomem_addr[27:0]} | iomem_wdata, 0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    @(negedge clk);
    check("post_rst_cmd_ready", cmd_ready, 1);
    @(posedge clk);
    #1;

    // full-strobe write with wait states
    resp_wait = 2;
    b0 = bus_cnt;
    exp_q.push_back(8'h4B);
    send_write(32'h0300_0000, 8'h0F, 32'h0000_00A5);
    @(negedge clk);
    check("wr_valid_latency", iomem_valid, 1);
    check("wr_cmd_ready_low", cmd_ready, 0);
    wait_idle("wr_done");
    check("wr_bus_cnt", bus_cnt - b0, 1);
    check("wr_addr", bus_addr, 32'h0300_0000);
    check("wr_wstrb", bus_wstrb, 4'hF);
    check("wr_wdata", bus_wdata, 32'h0000_00A5);

    // read, 3 wait cycles
    resp_wait = 3;
    resp_data = 32'h1234_56A5;
    push4(32'h1234_56A5);
    send_read(32'h0300_0000);
    @(negedge clk);
    check("rd_wstrb_bus", iomem_wstrb, 0);
    wait_idle("rd_done");
    check("rd_addr", bus_addr, 32'h0300_0000);
    check("rd_wstrb", bus_wstrb, 0);

    // read with response backpressure after 2 bytes
    resp_wait = 0;
    resp_data = 32'hCAFE_F00D;
    base = rsp_idx;
    push4(32'hCAFE_F00D);
    send_read(32'h0200_0010);
    for (int i = 0; i < 100; i++) begin
      @(posedge clk);
      #1;
      if (rsp_idx >= base + 2) break;
    end
    rsp_ready = 1'b0;
    repeat (5) @(posedge clk);
    #1;
    check("bp_no_transfer", rsp_idx, base + 2);
    rsp_ready = 1'b1;
    wait_idle("bp_done");
    check("bp_addr", bus_addr, 32'h0200_0010);

    // bad opcode followed by a valid read
    exp_q.push_back(8'h3F);
    send_byte(8'h00);
    resp_data = 32'h89AB_CDEF;
    push4(32'h89AB_CDEF);
    send_read(32'h0300_0004);
    wait_idle("bad_op_done");

    // high strobe nibble ignored; zero-strobe write still runs a bus cycle
    exp_q.push_back(8'h4B);
    send_write(32'h0300_0008, 8'hF3, 32'h1122_3344);
    wait_idle("wr_strb3_done");
    check("wr_strb3_wstrb", bus_wstrb, 4'h3);
    check("wr_strb3_wdata", bus_wdata, 32'h1122_3344);
    b0 = bus_cnt;
    exp_q.push_back(8'h4B);
    send_write(32'h0300_000C, 8'h00, 32'h5555_AAAA);
    wait_idle("wr_strb0_done");
    check("wr_strb0_cnt", bus_cnt - b0, 1);
    check("wr_strb0_wstrb", bus_wstrb, 4'h0);

    // reset while stuck in BUS
    resp_en = 1'b0;
    b0 = bus_cnt;
    send_read(32'h0400_0000);
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("stuck_valid", iomem_valid, 1);
    check("stuck_busy", busy, 1);
    @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("mid_rst_valid", iomem_valid, 0);
    check("mid_rst_busy", busy, 0);
    check("mid_rst_addr", iomem_addr, 0);
    @(posedge clk);
    #1;
    reset   = 1'b0;
    resp_en = 1'b1;
    check("mid_rst_no_bus", bus_cnt - b0, 0);
    exp_q.push_back(8'h4B);
    send_write(32'h0300_0010, 8'h0C, 32'hDEAD_BEEF);
    wait_idle("post_rst_wr_done");
    check("post_rst_addr", bus_addr, 32'h0300_0010);
    check("post_rst_wstrb", bus_wstrb, 4'hC);

`ifdef IOMEM_DBG_TIMEOUT_EN
    resp_en = 1'b0;
    exp_q.push_back(8'h54);
    send_read(32'h0500_0000);
    wait_idle("tmo_done");
    check("tmo_valid_len", last_vlen, TMO);
    resp_en   = 1'b1;
    resp_wait = TMO - 1;
    resp_data = 32'h0BAD_BEEF;
    push4(32'h0BAD_BEEF);
    send_read(32'h0500_0004);
    wait_idle("tmo_edge_done");
    check("tmo_edge_valid_len", last_vlen, TMO);
`endif

    check("rsp_total", rsp_idx, exp_q.size());
    $display("%0d/%0d checks passed", n_pass + m_pass, n_pass + n_fail + m_pass + m_fail);
    $finish;
  end

endmodule
